// File: rtl/c2c_w_arbiter_if.sv
// Core-to-cache write channel shared by requesters and the data cache.
// Masters drive we/sel/addr/data and hold them until ack; slaves return a single-cycle ack.
interface c2c_w #(
    parameter int XLEN = 32
);
    logic                we;
    logic [XLEN/8-1:0]   sel;
    logic [XLEN-1:0]     addr;
    logic [XLEN-1:0]     data;
    logic                ack;

    modport master (
        output we, sel, addr, data,
        input  ack
    );

    modport slave (
        input  we, sel, addr, data,
        output ack
    );
endinterface

// File: rtl/c2c_w_arbiter.sv
// Two-requester round-robin arbiter sharing one c2c_w write port into the data cache.
// The grant is registered and held until the cache acks, then priority rotates.
module c2c_w_arbiter #(
    parameter int XLEN = 32
) (
    input logic  clk,
    input logic  reset,
    c2c_w.slave  m0,
    c2c_w.slave  m1,
    c2c_w.master s
);
    localparam int SEL_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_gnt;
    logic   next_last_gnt;

    // last_gnt=1 after reset so requester 0 wins the first contest
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state    <= next_state;
            last_gnt <= next_last_gnt;
        end
    end

    always_comb begin
        next_state    = state;
        next_last_gnt = last_gnt;
        case (state)
            IDLE: begin
                if (m0.we && m1.we)
                    next_state = last_gnt ? GNT0 : GNT1;
                else if (m0.we)
                    next_state = GNT0;
                else if (m1.we)
                    next_state = GNT1;
            end
            GNT0: begin
                if (s.ack) begin
                    next_last_gnt = 1'b0;
                    if (m1.we)
                        next_state = GNT1;
                    else if (m0.we)
                        next_state = GNT0;
                    else
                        next_state = IDLE;
                end else if (!m0.we) begin
                    next_state = IDLE;
                end
            end
            GNT1: begin
                if (s.ack) begin
                    next_last_gnt = 1'b1;
                    if (m0.we)
                        next_state = GNT0;
                    else if (m1.we)
                        next_state = GNT1;
                    else
                        next_state = IDLE;
                end else if (!m1.we) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Pure mux from the granted requester; nothing is buffered here
    always_comb begin
        s.we  = 1'b0;
        s.sel = {SEL_W{1'b0}};
        s.addr = {XLEN{1'b0}};
        s.data = {XLEN{1'b0}};
        m0.ack = 1'b0;
        m1.ack = 1'b0;
        case (state)
            GNT0: begin
                s.we   = m0.we;
                s.sel  = m0.sel;
                s.addr = m0.addr;
                s.data = m0.data;
                m0.ack = s.ack;
            end
            GNT1: begin
                s.we   = m1.we;
                s.sel  = m1.sel;
                s.addr = m1.addr;
                s.data = m1.data;
                m1.ack = s.ack;
            end
            default: ;
        endcase
    end
endmodule
